// File: rtl/cpu_mem_loader_if.sv
// Bus bundle between the memory-side loader and its cpu/stream neighbours.
// The slave modport is the loader's view; master is the cpu/stream side.
interface cpu_mem_loader_if #(
   parameter int IMSB = 15,
   parameter int PMSB = 7,
   parameter int AMSB = 7,
   parameter int DMSB = 7
);
   logic          start;
   logic          byte_valid;
   logic [7:0]    byte_data;
   logic          byte_ready;
   logic          setn;
   logic          busy;
   logic          done;
   logic [15:0]   run_cycles;
   logic [PMSB:0] pc;
   logic [IMSB:0] inst;
   logic [AMSB:0] addr;
   logic          write;
   logic [DMSB:0] wdata;
   logic          idle;
   logic [DMSB:0] rdata;

   modport slave (
      input  start, byte_valid, byte_data, pc, addr, write, wdata, idle,
      output byte_ready, setn, busy, done, run_cycles, inst, rdata
   );

   modport master (
      output start, byte_valid, byte_data, pc, addr, write, wdata, idle,
      input  byte_ready, setn, busy, done, run_cycles, inst, rdata
   );
endinterface

// File: rtl/cpu_mem_loader.sv
// Boot loader and memory responder for the accumulator cpu: streams bytes into
// RAM then ROM, releases the cpu, counts run cycles and flags completion.
module cpu_mem_loader #(
   parameter int IMSB = 15,
   parameter int PMSB = 7,
   parameter int AMSB = 7,
   parameter int DMSB = 7
) (
   input logic              clk,
   input logic              rstn,
   cpu_mem_loader_if.slave  bus
);
   localparam int CW = (AMSB > PMSB) ? AMSB + 1 : PMSB + 1;

   typedef enum logic [2:0] {
      S_IDLE, S_LD_RAM, S_LD_ROM_LO, S_LD_ROM_HI, S_SETTLE, S_RUN, S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    lo_q, lo_d;
   logic          setn_q, setn_d;
   logic          done_q, done_d;
   logic [15:0]   run_q, run_d;
   logic [IMSB:0] inst_q;
   logic [DMSB:0] rdata_q;

   logic [IMSB:0] rom [2**(PMSB+1)];
   logic [DMSB:0] ram [2**(AMSB+1)];

   logic          ready, xfer;
   logic          ram_we, rom_we;
   logic [AMSB:0] ram_wa;
   logic [DMSB:0] ram_wd;

   assign ready = (state_q == S_LD_RAM) || (state_q == S_LD_ROM_LO) ||
                  (state_q == S_LD_ROM_HI);
   assign xfer  = ready && bus.byte_valid;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lo_d    = lo_q;
      done_d  = done_q;
      run_d   = run_q;
      ram_we  = 1'b0;
      ram_wa  = bus.addr;
      ram_wd  = bus.wdata;
      rom_we  = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               state_d = S_LD_RAM;
               cnt_d   = '0;
               done_d  = 1'b0;
               run_d   = '0;
            end
         end
         S_LD_RAM: begin
            if (xfer) begin
               ram_we = 1'b1;
               ram_wa = cnt_q[AMSB:0];
               ram_wd = bus.byte_data;
               if (cnt_q[AMSB:0] == '1) begin
                  cnt_d   = '0;
                  state_d = S_LD_ROM_LO;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_LD_ROM_LO: begin
            if (xfer) begin
               lo_d    = bus.byte_data;
               state_d = S_LD_ROM_HI;
            end
         end
         S_LD_ROM_HI: begin
            if (xfer) begin
               rom_we = 1'b1;
               if (cnt_q[PMSB:0] == '1) begin
                  cnt_d   = '0;
                  state_d = S_SETTLE;
               end else begin
                  cnt_d   = cnt_q + 1'b1;
                  state_d = S_LD_ROM_LO;
               end
            end
         end
         // One idle cycle lets inst pick up rom[0] before the cpu is released.
         S_SETTLE: state_d = S_RUN;
         S_RUN: begin
            ram_we = bus.write;
            run_d  = (run_q == '1) ? run_q : run_q + 1'b1;
            if (bus.idle) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      setn_d = (state_d == S_RUN);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         lo_q    <= '0;
         setn_q  <= 1'b0;
         done_q  <= 1'b0;
         run_q   <= '0;
         inst_q  <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lo_q    <= lo_d;
         setn_q  <= setn_d;
         done_q  <= done_d;
         run_q   <= run_d;
         inst_q  <= rom[bus.pc];
         rdata_q <= ram[bus.addr];
      end
   end

   // Memory contents survive reset; writes are gated by state, which reset forces to IDLE.
   always_ff @(posedge clk) begin
      if (ram_we) ram[ram_wa] <= ram_wd;
      if (rom_we) rom[cnt_q[PMSB:0]] <= {bus.byte_data, lo_q};
   end

   assign bus.byte_ready = ready;
   assign bus.setn       = setn_q;
   assign bus.busy       = (state_q != S_IDLE) && (state_q != S_DONE);
   assign bus.done       = done_q;
   assign bus.run_cycles = run_q;
   assign bus.inst       = inst_q;
   assign bus.rdata      = rdata_q;
endmodule

// File: doc/cpu_mem_loader.md
Name: cpu_mem_loader

Overview:
- Memory-side responder and boot loader for the 16-bit-instruction accumulator cpu.
- Holds the data RAM and the instruction ROM, and serves the cpu fetch port (pc -> inst) and data port (addr/write/wdata -> rdata).
- Before execution, fills RAM and then ROM from a byte stream using a valid/ready handshake.
- Releases the cpu via setn, counts run cycles, and flags done when the cpu reports idle.

Parameters:
IMSB, 15, instruction MSB; fixed at 15, since ROM words are loaded as two bytes
PMSB, 7, pc MSB; ROM depth = 2^(PMSB+1)
AMSB, 7, addr MSB; RAM depth = 2^(AMSB+1)
DMSB, 7, data MSB; fixed at 7, since RAM is loaded one byte per entry

Ports:
clk  in  1  clock; all state updates on posedge
rstn  in  1  asynchronous active-low reset
start  in  1  pulse that begins a load-and-run sequence
byte_valid  in  1  stream byte present
byte_data  in  8  stream byte
byte_ready  out  1  loader accepts the byte this cycle
setn  out  1  cpu run enable; 0 holds the cpu pc at 0
busy  out  1  sequence in progress
done  out  1  cpu halted; sticky until the next start
run_cycles  out  16  number of RUN cycles, saturating at 16'hFFFF
pc  in  PMSB+1  cpu fetch address
inst  out  IMSB+1  registered rom[pc]
addr  in  AMSB+1  cpu data address
write  in  1  cpu write strobe
wdata  in  DMSB+1  cpu write data
idle  in  1  cpu idle/halt indication
rdata  out  DMSB+1  registered ram[addr]

Behaviour:
- Reset values: state=IDLE; setn=0; byte_ready=0; busy=0; done=0; run_cycles=0; inst=0; rdata=0; load counter=0. Memory contents are not reset.
- Read ports:
  - Every posedge when not in reset: inst<=rom[pc] and rdata<=ram[addr]. Latency is 1 cycle.
  - A read in the same cycle as a write to the same location returns the old data (read-before-write).
- cpu writes: ram[addr]<=wdata when state==RUN && write. write is ignored in every other state.
- Handshake: byte_ready=1 only in LD_RAM, LD_ROM_LO and LD_ROM_HI. A byte transfers on a posedge with byte_valid&&byte_ready. A cycle without valid stalls the FSM with no state change.
- State machine:
  - IDLE/DONE: start -> LD_RAM. Entering LD_RAM clears cnt, done and run_cycles. busy=1 in every state except IDLE and DONE.
  - LD_RAM: each transfer writes ram[cnt]<=byte_data and increments cnt. After the transfer at cnt=2^(AMSB+1)-1, go to LD_ROM_LO with cnt=0.
  - LD_ROM_LO: on transfer, latch lo<=byte_data, then go to LD_ROM_HI.
  - LD_ROM_HI: on transfer, write rom[cnt]<={byte_data,lo} (little-endian) and increment cnt. After cnt=2^(PMSB+1)-1, go to SETTLE; otherwise go to LD_ROM_LO.
  - SETTLE: lasts 1 cycle so that inst holds rom[0] (pc is 0 while setn=0), then go to RUN.
  - RUN: setn=1 (registered, asserted the same cycle the state becomes RUN). run_cycles increments each RUN cycle and saturates.
    - If idle is sampled high in RUN, go to DONE with setn=0 and done=1. The count includes that cycle.
    - A word of 0 at rom[0] therefore gives done after exactly 1 RUN cycle with run_cycles=1.
  - start is ignored in every state other than IDLE and DONE.
- Wrap-around: cnt widths are AMSB+1 and PMSB+1; the terminal compare uses all-ones, so no extra bit is needed.
- Reset mid-operation: an asynchronous return to IDLE. Partially loaded memory is retained. setn drops immediately.
- setn is 0 in every non-RUN state.

Test Plan:
- Reset: hold rstn=0 with random inputs -> setn=0, busy=0, done=0, inst=0, rdata=0, byte_ready=0.
- Full load:
  - Stimulus: start, then 256 RAM bytes (value=index), then ROM bytes giving rom[0]=16'h1234 and rom[1..255]=0.
  - Required: after the final byte, 1 SETTLE cycle, inst==16'h1234 at the first RUN cycle, and setn rises.
  - With the bench driving idle=0, then idle=1 on the 3rd RUN cycle: done=1, setn=0, run_cycles=3.
- Handshake stall: deassert byte_valid for 5 cycles mid-LD_RAM -> cnt unchanged, no RAM write. Resume -> the remaining bytes land at the correct indices (readback ram[0x80]==8'h80).
- cpu data port in RUN:
  - addr=0x10, write=1, wdata=8'hA5 -> next cycle rdata==8'hA5.
  - Same-cycle read of 0x11 -> returns the loaded value 8'h11.
  - write=1 in IDLE -> RAM unchanged.
- Reset mid-LD_ROM: assert rstn=0 after 10 ROM bytes -> state IDLE, busy=0. A new start reloads from RAM index 0.
- start ignored while busy: pulse start during LD_RAM and during RUN -> no restart, cnt and run_cycles continue. start in DONE -> done clears, run_cycles=0, byte_ready=1.
